// File: rtl/cordic_pipe_param_if.sv
// rtl/cordic_pipe_param_if.sv - sample-in / result-out bundle for the CORDIC pipeline
interface cordic_pipe_param_if #(
   parameter int WIDTH = 16,
   parameter int ANG_W = 16
);
   logic                    ce;
   logic                    in_valid;
   logic                    mode;
   logic signed [WIDTH-1:0] xin;
   logic signed [WIDTH-1:0] yin;
   logic signed [ANG_W-1:0] ang;
   logic                    out_valid;
   logic signed [WIDTH-1:0] Xout;
   logic signed [WIDTH-1:0] Yout;
   logic signed [ANG_W-1:0] Zout;

   modport master (
      output ce, in_valid, mode, xin, yin, ang,
      input  out_valid, Xout, Yout, Zout
   );

   modport slave (
      input  ce, in_valid, mode, xin, yin, ang,
      output out_valid, Xout, Yout, Zout
   );
endinterface

// File: rtl/cordic_pipe_param.sv
// rtl/cordic_pipe_param.sv - pipelined CORDIC, rotation/vectoring, quadrant pre-rotation, gain-compensated
module cordic_pipe_param #(
   parameter int WIDTH  = 16,
   parameter int ANG_W  = 16,
   parameter int STAGES = 14,
   parameter int GUARD  = 2
) (
   input logic clk,
   input logic reset,
   cordic_pipe_param_if.slave bus
);
   localparam int IW = WIDTH + GUARD + 1;
   localparam int PW = IW + 17;
   localparam logic signed [ANG_W-1:0] HALF_PI = {2'b01, {(ANG_W-2){1'b0}}};
   localparam logic signed [PW-1:0]    KQ      = PW'(39797);
   localparam logic signed [PW-1:0]    RND     = PW'(32768);
   localparam logic signed [PW-1:0]    MAXP    = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0]    MINP    = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   // atan(2^-i) in 2^32-per-turn units; rescaled to ANG_W with round-to-nearest
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:  return 32'h20000000;  1:  return 32'h12E4051E;
         2:  return 32'h09FB385B;  3:  return 32'h051111D4;
         4:  return 32'h028B0D43;  5:  return 32'h0145D7E1;
         6:  return 32'h00A2F61E;  7:  return 32'h00517C55;
         8:  return 32'h0028BE53;  9:  return 32'h00145F2F;
         10: return 32'h000A2F98;  11: return 32'h000517CC;
         12: return 32'h00028BE6;  13: return 32'h000145F3;
         14: return 32'h0000A2FA;  15: return 32'h0000517D;
         16: return 32'h000028BE;  17: return 32'h0000145F;
         18: return 32'h00000A30;  19: return 32'h00000518;
         20: return 32'h0000028C;  21: return 32'h00000146;
         22: return 32'h000000A3;  23: return 32'h00000051;
         24: return 32'h00000029;  25: return 32'h00000014;
         26: return 32'h0000000A;  27: return 32'h00000005;
         28: return 32'h00000003;  29: return 32'h00000001;
         30: return 32'h00000001;
         default: return 32'h00000000;
      endcase
   endfunction

   function automatic logic signed [ANG_W-1:0] atan_q(input int i);
      logic [32:0] t;
      t = {1'b0, atan32(i)} + (33'd1 << (31 - ANG_W));
      return ANG_W'(t >> (32 - ANG_W));
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
      if (v > MAXP)
         return {1'b0, {(WIDTH-1){1'b1}}};
      else if (v < MINP)
         return {1'b1, {(WIDTH-1){1'b0}}};
      else
         return $signed(v[WIDTH-1:0]);
   endfunction

   // index 0 holds the pre-rotated sample, index i+1 the result of iteration i
   logic [STAGES:0]         v_r;
   logic [STAGES-1:0]       m_r;
   logic signed [IW-1:0]    x_r [0:STAGES];
   logic signed [IW-1:0]    y_r [0:STAGES];
   logic signed [ANG_W-1:0] z_r [0:STAGES];
   logic signed [IW-1:0]    x_n [0:STAGES-1];
   logic signed [IW-1:0]    y_n [0:STAGES-1];
   logic signed [ANG_W-1:0] z_n [0:STAGES-1];

   logic                    ov_r;
   logic signed [WIDTH-1:0] xo_r, yo_r;
   logic signed [ANG_W-1:0] zo_r;

   logic signed [IW-1:0]    xe, ye, px, py;
   logic signed [ANG_W-1:0] pz;
   logic [1:0]              q;
   logic signed [PW-1:0]    xm, ym;

   assign xe = IW'(bus.xin);
   assign ye = IW'(bus.yin);
   assign q  = bus.ang[ANG_W-1 -: 2];

   // bring the vector into the right half-plane; IW leaves room to negate -2^(WIDTH-1)
   always_comb begin
      px = xe;
      py = ye;
      pz = bus.ang;
      if (bus.mode) begin
         pz = '0;
         if (xe[IW-1]) begin
            if (!ye[IW-1]) begin
               px = ye;  py = -xe; pz = HALF_PI;
            end else begin
               px = -ye; py = xe;  pz = -HALF_PI;
            end
         end
      end else begin
         case (q)
            2'b01: begin px = -ye; py = xe;  pz = bus.ang - HALF_PI; end
            2'b10: begin px = ye;  py = -xe; pz = bus.ang + HALF_PI; end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         if (m_r[i] ? y_r[i][IW-1] : !z_r[i][ANG_W-1]) begin
            x_n[i] = x_r[i] - (y_r[i] >>> i);
            y_n[i] = y_r[i] + (x_r[i] >>> i);
            z_n[i] = z_r[i] - atan_q(i);
         end else begin
            x_n[i] = x_r[i] + (y_r[i] >>> i);
            y_n[i] = y_r[i] - (x_r[i] >>> i);
            z_n[i] = z_r[i] + atan_q(i);
         end
      end
   end

   assign xm = (PW'(x_r[STAGES]) * KQ + RND) >>> 16;
   assign ym = (PW'(y_r[STAGES]) * KQ + RND) >>> 16;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_r  <= '0;
         m_r  <= '0;
         for (int i = 0; i <= STAGES; i++) begin
            x_r[i] <= '0;
            y_r[i] <= '0;
            z_r[i] <= '0;
         end
         ov_r <= 1'b0;
         xo_r <= '0;
         yo_r <= '0;
         zo_r <= '0;
      end else if (bus.ce) begin
         v_r    <= {v_r[STAGES-1:0], bus.in_valid};
         m_r    <= {m_r[STAGES-2:0], bus.mode};
         x_r[0] <= px;
         y_r[0] <= py;
         z_r[0] <= pz;
         for (int i = 0; i < STAGES; i++) begin
            x_r[i+1] <= x_n[i];
            y_r[i+1] <= y_n[i];
            z_r[i+1] <= z_n[i];
         end
         ov_r <= v_r[STAGES];
         xo_r <= sat(xm);
         yo_r <= sat(ym);
         zo_r <= z_r[STAGES];
      end
   end

   assign bus.out_valid = ov_r;
   assign bus.Xout      = xo_r;
   assign bus.Yout      = yo_r;
   assign bus.Zout      = zo_r;
endmodule

// File: tb/tb_cordic_pipe_param.sv
// tb/tb_cordic_pipe_param.sv - directed vector bench for cordic_pipe_param
module tb_cordic_pipe_param;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   int   stale;

   cordic_pipe_param_if #(.WIDTH(16), .ANG_W(16)) bus ();

   cordic_pipe_param #(.WIDTH(16), .ANG_W(16), .STAGES(14), .GUARD(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic  mode;
      int    x, y, a;
      int    ex, ey, ez, ztol;
      string name;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   task automatic chk(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act - exp > tol || exp - act > tol) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic chk_z(input string name, input logic [15:0] act, input int exp, input int tol);
      logic signed [15:0] d;
      d = act - 16'(exp);
      checks++;
      if (int'(d) > tol || int'(d) < -tol) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d, mod 2^16)", name, $signed(act), exp, tol);
      end
   endtask

   task automatic drive(input logic v, input logic m, input int x, input int y, input int a);
      bus.in_valid = v;
      bus.mode     = m;
      bus.xin      = 16'(x);
      bus.yin      = 16'(y);
      bus.ang      = 16'(a);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         n++;
      end while (!bus.out_valid && n < 60);
   endtask

   task automatic chk_res(input string name, input int ex, input int ey, input int ez, input int ztol);
      chk({name, " X"}, int'(bus.Xout), ex, 4);
      chk({name, " Y"}, int'(bus.Yout), ey, 4);
      chk_z({name, " Z"}, bus.Zout, ez, ztol);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0,  16384,      0, 'h2000,  11585,  11585,      0, 2, "rot45"};
      tbl[1]  = '{1'b0,  16384,      0, 'h4000,      0,  16384,      0, 2, "rot90"};
      tbl[2]  = '{1'b0,  16384,      0, 'h8000, -16384,      0,      0, 2, "rot180"};
      tbl[3]  = '{1'b0,      0,  10000, 'hC000,  10000,      0,      0, 2, "rotm90"};
      tbl[4]  = '{1'b0, -20000,      0, 'h6000,  14142, -14142,      0, 2, "rot135"};
      tbl[5]  = '{1'b0,  32767,  32767, 'h2000,      0,  32767,      0, 2, "rot_satp"};
      tbl[6]  = '{1'b0, -32768, -32768, 'h2000,      0, -32768,      0, 2, "rot_satn"};
      tbl[7]  = '{1'b1,  -8192,   8192, 'h1234,  11585,      0,  24576, 4, "vec135"};
      tbl[8]  = '{1'b1,  32767,  32767,      0,  32767,      0,   8192, 4, "vec_sat"};
      tbl[9]  = '{1'b1,   1000,  -1000,      0,   1414,      0,  -8192, 4, "vec_q4"};
      tbl[10] = '{1'b1, -10000,  -5000,      0,  11180,      0, -27932, 4, "vec_q3"};

      bus.ce = 1'b1;
      drive(1'b0, 1'b0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset valid", int'(bus.out_valid), 0, 0);
      chk("reset X", int'(bus.Xout), 0, 0);
      chk("reset Z", int'(bus.Zout), 0, 0);
      reset = 1'b0;

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         drive(1'b1, tbl[k].mode, tbl[k].x, tbl[k].y, tbl[k].a);
         wait_out(lat);
         chk({tbl[k].name, " latency"}, lat, 16, 0);
         chk_res(tbl[k].name, tbl[k].ex, tbl[k].ey, tbl[k].ez, tbl[k].ztol);
      end

      // valid / bubble / valid with alternating mode
      @(negedge clk);
      drive(1'b1, 1'b0, 16384, 0, 'h2000);
      @(negedge clk);
      drive(1'b0, 1'b1, 12345, -999, 'h7777);
      @(negedge clk);
      drive(1'b1, 1'b1, -8192, 8192, 0);
      wait_out(lat);
      chk("stream latency", lat, 14, 0);
      chk_res("stream rot", 11585, 11585, 0, 2);
      @(negedge clk);
      chk("stream bubble", int'(bus.out_valid), 0, 0);
      @(negedge clk);
      chk("stream valid2", int'(bus.out_valid), 1, 0);
      chk_res("stream vec", 11585, 0, 24576, 4);

      // ce low for 5 cycles mid-flight, then again while the result is presented
      @(negedge clk);
      drive(1'b1, 1'b0, 16384, 0, 'h4000);
      lat = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
         if (lat == 8)  bus.ce = 1'b0;
         if (lat == 13) bus.ce = 1'b1;
      end while (!bus.out_valid && lat < 60);
      chk("stall latency", lat, 21, 0);
      bus.ce = 1'b0;
      repeat (5) @(negedge clk);
      chk("hold valid", int'(bus.out_valid), 1, 0);
      chk_res("hold", 0, 16384, 0, 2);
      bus.ce = 1'b1;
      @(negedge clk);
      chk("hold release", int'(bus.out_valid), 0, 0);

      // asynchronous reset with a full pipe
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 16384, 0, 'h2000);
      end
      #2;
      chk("pre-reset valid", int'(bus.out_valid), 1, 0);
      reset = 1'b1;
      #1;
      chk("async valid", int'(bus.out_valid), 0, 0);
      chk("async X", int'(bus.Xout), 0, 0);
      chk("async Y", int'(bus.Yout), 0, 0);
      chk("async Z", int'(bus.Zout), 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      stale = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("stale valid", stale, 0, 0);
      drive(1'b1, 1'b1, -10000, -5000, 0);
      wait_out(lat);
      chk("post-reset latency", lat, 16, 0);
      chk_res("post-reset", 11180, 0, -27932, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
